// File: rtl/mc_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// mc_ctrl_fsm
//
// Multicycle control sequencer for the MIPS datapath. Fetch, decode/register
// read, execute, memory access and write-back share one ALU and one memory
// port, so each instruction walks through a short sequence of states. Every
// datapath mux select and write strobe is driven from here.
//
// Optional feature (macro ILLEGAL_TRAP_EN):
//   defined   - an unrecognised opcode in DECODE parks the FSM in TRAP with
//               trap=1 until reset.
//   undefined - an unrecognised opcode retires as a NOP; trap is tied to 0.
//
// Ports:
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   run            0 = hold state/count and suppress all write strobes
//   opcode[5:0]    instr[31:26], sampled only in DECODE
//   mem_ready      memory completes the current access this cycle
//   pc_write, pc_write_cond, ir_write, mem_write, reg_write   write strobes
//   i_or_d, mem_read, mem_to_reg, reg_dst, alu_src_a          selects/requests
//   alu_src_b[1:0], alu_op[1:0], pc_source[1:0]               mux selects
//   state[3:0]     current state encoding (debug)
//   trap           illegal opcode seen (ILLEGAL_TRAP_EN only)
//   retired        retired-instruction count, wraps modulo 2^CNT_W
// ---------------------------------------------------------------------------
module mc_ctrl_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             ir_write,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic [3:0]       state,
  output logic             trap,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    R_EXEC    = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    I_EXEC    = 4'd10,
    I_WB      = 4'd11,
    TRAP      = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [5:0]       opcode_q, opcode_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire;

  // State register, latched opcode and retired counter. The opcode is kept
  // so MEM_ADDR can still tell lw from sw after the decoder has moved on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FETCH;
      opcode_q  <= 6'd0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      retired_q <= retired_d;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic trap_q, trap_d;

  // Sticky trap flag, set on the same edge that enters TRAP. TRAP is only
  // left through reset, so the flag simply follows entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trap_q <= 1'b0;
    end else begin
      trap_q <= trap_d;
    end
  end

  always_comb begin
    trap_d = trap_q | (state_d == TRAP);
  end

  assign trap = trap_q;
`else
  assign trap = 1'b0;
`endif

  // Next-state logic. Nothing advances while run is low (TRAP is parked
  // regardless), and a mem_ready seen during a hold is ignored because the
  // whole transition is suppressed. retire flags every edge that completes
  // an instruction so the counter can follow it.
  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    retire    = 1'b0;
    retired_d = retired_q;
    if (run) begin
      case (state_q)
        FETCH: begin
          if (mem_ready) state_d = DECODE;
        end
        DECODE: begin
          opcode_d = opcode;
          case (opcode)
            OP_LW, OP_SW: state_d = MEM_ADDR;
            OP_RTYPE:     state_d = R_EXEC;
            OP_BEQ:       state_d = BRANCH;
            OP_J:         state_d = JUMP;
            OP_ADDI:      state_d = I_EXEC;
            default: begin
`ifdef ILLEGAL_TRAP_EN
              state_d = TRAP;
`else
              state_d = FETCH;
              retire  = 1'b1;
`endif
            end
          endcase
        end
        MEM_ADDR: begin
          state_d = (opcode_q == OP_SW) ? MEM_WRITE : MEM_READ;
        end
        MEM_READ: begin
          if (mem_ready) state_d = MEM_WB;
        end
        MEM_WRITE: begin
          if (mem_ready) begin
            state_d = FETCH;
            retire  = 1'b1;
          end
        end
        R_EXEC: state_d = R_WB;
        I_EXEC: state_d = I_WB;
        MEM_WB, R_WB, BRANCH, JUMP, I_WB: begin
          state_d = FETCH;
          retire  = 1'b1;
        end
`ifdef ILLEGAL_TRAP_EN
        TRAP: state_d = TRAP;
`endif
        default: state_d = FETCH;
      endcase
    end
`ifdef ILLEGAL_TRAP_EN
    else if (state_q == TRAP) begin
      state_d = TRAP;
    end
`endif
    if (retire) retired_d = retired_q + CNT_ONE;
  end

  // Moore output decode. Selects and mem_read come straight from the state;
  // write strobes are additionally gated by run so a hold never writes, and
  // the FETCH strobes also wait for the instruction to arrive (mem_ready).
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready & run;
        pc_write  = mem_ready & run;
      end
      DECODE: begin
        alu_src_b = 2'b11;
      end
      MEM_ADDR, I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      MEM_WB: begin
        reg_write  = run;
        mem_to_reg = 1'b1;
      end
      MEM_WRITE: begin
        mem_write = run;
        i_or_d    = 1'b1;
      end
      R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      R_WB: begin
        reg_write = run;
        reg_dst   = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = run;
        pc_source     = 2'b01;
      end
      JUMP: begin
        pc_write  = run;
        pc_source = 2'b10;
      end
      I_WB: begin
        reg_write = run;
      end
      default: begin
      end
    endcase
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_mc_ctrl_fsm
//
// Directed bench for the multicycle control FSM. Each instruction is expanded
// into the list of states it must visit (from its opcode, memory wait cycles
// and any run-hold), every cycle's expected control word is looked up from a
// per-state table, and a compare process checks the DUT on each falling edge.
// A narrow counter width makes the retired-count wrap reachable.
// ---------------------------------------------------------------------------
module tb_mc_ctrl_fsm;

  localparam int TB_CNT_W = 3;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  logic                clk;
  logic                rst;
  logic                run;
  logic [5:0]          opcode;
  logic                mem_ready;
  logic                pc_write;
  logic                pc_write_cond;
  logic                ir_write;
  logic                i_or_d;
  logic                mem_read;
  logic                mem_write;
  logic                mem_to_reg;
  logic                reg_write;
  logic                reg_dst;
  logic                alu_src_a;
  logic [1:0]          alu_src_b;
  logic [1:0]          alu_op;
  logic [1:0]          pc_source;
  logic [3:0]          state;
  logic                trap;
  logic [TB_CNT_W-1:0] retired;

  int                  nVec = 0;
  int                  nFail = 0;
  logic                checkEn = 1'b0;
  int                  expState = 0;
  logic [TB_CNT_W-1:0] expRetired = '0;
  logic                expTrap = 1'b0;
  logic [5:0]          curOp = 6'd0;
  int                  holdSt = -1;
  int                  holdN = 0;

  mc_ctrl_fsm #(.CNT_W(TB_CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .run           (run),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .ir_write      (ir_write),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .reg_dst       (reg_dst),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .state         (state),
    .trap          (trap),
    .retired       (retired)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected control word for a state, as the table of required outputs.
  // Packing: {pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write,
  // mem_to_reg, reg_write, reg_dst, alu_src_a, alu_src_b, alu_op, pc_source}.
  function automatic logic [15:0] expCtrl(input int st, input logic rdy, input logic rn);
    logic pw, pwc, irw, iod, mr, mw, m2r, rw, rd, asa;
    logic [1:0] asb, aop, psrc;
    {pw, pwc, irw, iod, mr, mw, m2r, rw, rd, asa} = '0;
    asb = 2'b00;
    aop = 2'b00;
    psrc = 2'b00;
    case (st)
      0:  begin mr = 1; asb = 2'b01; irw = rdy & rn; pw = rdy & rn; end
      1:  asb = 2'b11;
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mr = 1; iod = 1; end
      4:  begin rw = rn; m2r = 1; end
      5:  begin mw = rn; iod = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rw = rn; rd = 1; end
      8:  begin asa = 1; aop = 2'b01; pwc = rn; psrc = 2'b01; end
      9:  begin pw = rn; psrc = 2'b10; end
      10: begin asa = 1; asb = 2'b10; end
      11: rw = rn;
      default: begin end
    endcase
    return {pw, pwc, irw, iod, mr, mw, m2r, rw, rd, asa, asb, aop, psrc};
  endfunction

  // Single comparison: counts the vector and reports any difference.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Per-cycle compare against the model, mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("state", {28'd0, state}, expState);
      checkOutput("ctrl", {16'd0, pc_write, pc_write_cond, ir_write, i_or_d, mem_read,
                           mem_write, mem_to_reg, reg_write, reg_dst, alu_src_a,
                           alu_src_b, alu_op, pc_source},
                  {16'd0, expCtrl(expState, mem_ready, run)});
      checkOutput("retired", {{(32-TB_CNT_W){1'b0}}, retired}, {{(32-TB_CNT_W){1'b0}}, expRetired});
      checkOutput("trap", {31'd0, trap}, {31'd0, expTrap});
    end
  end

  // Drive one cycle in which the DUT must sit in state st. The opcode bus
  // carries garbage outside DECODE to show it is sampled only there.
  task automatic applyStimulus(input int st, input logic rdy, input logic rn);
    expState  = st;
    mem_ready = rdy;
    run       = rn;
    opcode    = (st == 1) ? curOp : OP_BAD;
    @(posedge clk);
    #1;
  endtask

  // Like applyStimulus, but first inserts the pending run-hold cycles when
  // this state is the one chosen for a hold. mem_ready is high during the
  // hold, which the DUT must ignore.
  task automatic stepState(input int st, input logic rdy);
    if (st == holdSt && holdN > 0) begin
      for (int n = 0; n < holdN; n++) applyStimulus(st, 1'b1, 1'b0);
      holdN = 0;
    end
    applyStimulus(st, rdy, 1'b1);
  endtask

  // One whole instruction: state path derived from the opcode class.
  task automatic runInstr(input logic [5:0] op, input int fetchWait, input int memWait);
    curOp = op;
    for (int i = 0; i < fetchWait; i++) stepState(0, 1'b0);
    stepState(0, 1'b1);
    stepState(1, 1'b1);
    case (op)
      OP_LW: begin
        stepState(2, 1'b1);
        for (int i = 0; i < memWait; i++) stepState(3, 1'b0);
        stepState(3, 1'b1);
        stepState(4, 1'b1);
      end
      OP_SW: begin
        stepState(2, 1'b1);
        for (int i = 0; i < memWait; i++) stepState(5, 1'b0);
        stepState(5, 1'b1);
      end
      OP_R:    begin stepState(6, 1'b1); stepState(7, 1'b1); end
      OP_BEQ:  stepState(8, 1'b1);
      OP_J:    stepState(9, 1'b1);
      OP_ADDI: begin stepState(10, 1'b1); stepState(11, 1'b1); end
      default: begin
`ifdef ILLEGAL_TRAP_EN
        expTrap = 1'b1;
        for (int i = 0; i < 10; i++) applyStimulus(12, i[0], i[0]);
        return;
`endif
      end
    endcase
    expRetired = expRetired + 1'b1;
  endtask

  initial begin
    rst       = 1'b1;
    run       = 1'b0;
    mem_ready = 1'b0;
    opcode    = 6'd0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstState", {28'd0, state}, 32'd0);
    checkOutput("rstRetired", {29'd0, retired}, 32'd0);
    checkOutput("rstTrap", {31'd0, trap}, 32'd0);
    checkOutput("rstPcWrite", {31'd0, pc_write}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkEn = 1'b1;

    runInstr(OP_R, 0, 0);
    checkOutput("retiredAfterAdd", {29'd0, retired}, 32'd1);
    runInstr(OP_LW, 1, 2);
    runInstr(OP_SW, 0, 1);
    runInstr(OP_BEQ, 0, 0);
    checkOutput("retiredAfterBeq", {29'd0, retired}, 32'd4);
    runInstr(OP_ADDI, 2, 0);
    runInstr(OP_J, 0, 0);

    holdSt = 7;
    holdN  = 3;
    runInstr(OP_R, 0, 0);
    checkOutput("retiredAfterHold", {29'd0, retired}, 32'd7);
    holdSt = 3;
    holdN  = 2;
    runInstr(OP_LW, 0, 0);
    holdSt = -1;
    checkOutput("retiredWrap", {29'd0, retired}, 32'd0);

    // Reset while a store is waiting on memory: the write strobe must fall
    // immediately with the reset, not at the next edge.
    curOp = OP_SW;
    stepState(0, 1'b1);
    stepState(1, 1'b1);
    stepState(2, 1'b1);
    stepState(5, 1'b0);
    checkEn   = 1'b0;
    mem_ready = 1'b0;
    checkOutput("memWriteBeforeRst", {31'd0, mem_write}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("memWriteInRst", {31'd0, mem_write}, 32'd0);
    checkOutput("stateInRst", {28'd0, state}, 32'd0);
    checkOutput("retiredInRst", {29'd0, retired}, 32'd0);
    expRetired = '0;
    expTrap    = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkEn = 1'b1;

    runInstr(OP_R, 0, 0);
    checkOutput("retiredAfterRst", {29'd0, retired}, 32'd1);

    runInstr(OP_BAD, 0, 0);
`ifdef ILLEGAL_TRAP_EN
    checkOutput("trapState", {28'd0, state}, 32'd12);
    checkOutput("trapFlag", {31'd0, trap}, 32'd1);
    checkOutput("trapRetired", {29'd0, retired}, 32'd1);
`else
    checkOutput("nopState", {28'd0, state}, 32'd0);
    checkOutput("nopTrap", {31'd0, trap}, 32'd0);
    checkOutput("nopRetired", {29'd0, retired}, 32'd2);
`endif

    checkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multicycle control sequencer for the MIPS datapath: instruction fetch, decode/register-file read, ALU, memory and write-back share one ALU and one memory port.
- Takes the opcode field from the instruction decoder. Drives every mux select and write strobe.
- Handles variable-latency memory with a mem_ready handshake, counts retired instructions, and supports a run/hold input.

Parameters:
- CNT_W, 32, width of the retired-instruction counter (wraps modulo 2^CNT_W).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  when 0, FSM holds state; all write strobes forced 0.
- opcode  in  6  instr[31:26] from decoder; sampled only in DECODE.
- mem_ready  in  1  memory completes current read/write this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if ALU zero (gated in datapath).
- ir_write  out  1  load instruction register.
- i_or_d  out  1  memory address select: 0=PC, 1=ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- mem_to_reg  out  1  write-back data select: 1=MDR, 0=ALUOut.
- reg_write  out  1  register file write strobe.
- reg_dst  out  1  write register select: 1=rd, 0=rt.
- alu_src_a  out  1  ALU A select: 0=PC, 1=regOut1.
- alu_src_b  out  2  ALU B select: 00=regOut2, 01=const 4, 10=immValue, 11=immValue<<2.
- alu_op  out  2  to ALU control: 00=add, 01=sub, 10=use funct.
- pc_source  out  2  PC source: 00=ALU result, 01=ALUOut (branch target), 10=jumpDest.
- state  out  4  current state encoding, for debug.
- trap  out  1  illegal opcode seen; only with ILLEGAL_TRAP_EN.
- retired  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (async, immediate):
  - state=FETCH(0); retired=0; trap=0.
  - Outputs are Moore-decoded from state only, except the mem_ready-qualified strobes below.
- State encodings: FETCH0, DECODE1, MEM_ADDR2, MEM_READ3, MEM_WB4, MEM_WRITE5, R_EXEC6, R_WB7, BRANCH8, JUMP9, I_EXEC10, I_WB11, TRAP12. Any unlisted encoding goes to FETCH next cycle.
- Any output not listed for a state is 0.
- FETCH:
  - mem_read=1, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write=pc_write=mem_ready.
  - Go to DECODE when mem_ready; otherwise stay.
- DECODE: alu_src_b=11, alu_op=00. Next state by opcode:
  - 100011 (lw) or 101011 (sw) -> MEM_ADDR.
  - 000000 -> R_EXEC.
  - 000100 (beq) -> BRANCH.
  - 000010 (j) -> JUMP.
  - 001000 (addi) -> I_EXEC.
  - Otherwise see Optional Feature.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next: MEM_READ for lw, MEM_WRITE for sw (opcode latched in DECODE).
- MEM_READ: mem_read=1, i_or_d=1. Go to MEM_WB on mem_ready; otherwise stay.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1 -> FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1. Go to FETCH on mem_ready; otherwise stay.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10 -> R_WB.
- R_WB: reg_write=1, reg_dst=1 -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01 -> FETCH.
- JUMP: pc_write=1, pc_source=10 -> FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00 -> I_WB.
- I_WB: reg_write=1, reg_dst=0 -> FETCH.
- Latency: R-type/addi 4 cycles; lw 5; sw 4; beq/j 3. Add one cycle per mem_ready-low cycle in a memory state.
- Retired counter:
  - Increments by 1 on each transition into FETCH from MEM_WB, MEM_WRITE, R_WB, BRANCH, JUMP, I_WB.
  - Wraps all-ones -> 0.
  - Never increments from TRAP.
- run=0:
  - state and retired hold.
  - pc_write, pc_write_cond, ir_write, mem_write, reg_write forced 0.
  - mem_read and the mux selects keep their state-decoded values.
  - A mem_ready arriving while run=0 is ignored; the memory must re-assert it after run returns.
- Reset mid-instruction: abandons the instruction with no partial write strobe after rst rises; restarts in FETCH.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined: an unlisted opcode in DECODE goes to TRAP.
  - TRAP: all strobes 0; trap=1 (registered, set on entry).
  - TRAP holds until rst; run has no effect.
- Undefined:
  - An unlisted opcode in DECODE goes to FETCH as a NOP. The PC was already advanced in FETCH.
  - retired increments on that DECODE->FETCH transition. Encoding 12 behaves as unlisted.
  - trap is tied to 0.

Test Plan:
- add (opcode 000000), mem_ready=1 in FETCH -> states 0,1,6,7,0; reg_write=1 and reg_dst=1 only in cycle 4; alu_op=10 in cycle 3; retired 0->1.
- lw (100011), mem_ready low 2 cycles in MEM_READ -> states 0,1,2,3,3,3,4,0; mem_read=1 and i_or_d=1 throughout 3; mem_to_reg=1 in 4.
- sw (101011) then beq (000100) -> mem_write=1 in state 5; beq asserts pc_write_cond=1, pc_source=01 in state 8; retired=2.
- Pulse run=0 for 3 cycles while in R_WB -> state stays 7; reg_write=0 during hold, 1 on first run=1 cycle; retired increments once.
- rst asserted mid-MEM_WRITE with mem_write=1 -> mem_write drops same cycle; state=0; retired=0; FETCH resumes after release.
- Opcode 111111 -> with ILLEGAL_TRAP_EN: state=12, trap=1, stays through 10 cycles of run toggling. Without it: DECODE->FETCH, retired+1, trap=0.
